// File: rtl/vga_timing_pkg.sv
// Shared constants for the video timing generator: the 640x480@60 default mode,
// an 800x600@60 alternative, the default counter width, and a helper that sums
// the four regions of one axis into its total period.
package vga_timing_pkg;

  localparam int CNT_W_DEF = 12;

  // 640x480 @ 60 Hz, 25.175 MHz pixel rate, both syncs active-low
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_H_POL    = 0;
  localparam int VGA640_V_POL    = 0;

  // 800x600 @ 60 Hz, 40 MHz pixel rate, both syncs active-high
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int SVGA800_H_POL    = 1;
  localparam int SVGA800_V_POL    = 1;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the timing generator: a wrapping counter
// with region decode. Ports: clkin/reset, step (advance by one), count (current
// position), wrap (count is the last position), in_active, in_sync (raw, unpolarised).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP,
  parameter int POL    = VGA640_H_POL,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_active,
  output logic             in_sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // Inclusive upper bounds, so a period that exactly fills 2**CNT_W never
  // needs a constant that would wrap to zero.
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);

  if (TOTAL > (longint'(1) << CNT_W)) begin : g_total_too_wide
    $error("vga_axis_counter: period %0d does not fit in %0d bits", TOTAL, CNT_W);
  end
  if (ACTIVE < 1 || SYNC < 1 || FP < 0 || BP < 0) begin : g_bad_regions
    $error("vga_axis_counter: ACTIVE and SYNC must be >= 1, porches >= 0");
  end
  if (POL != 0 && POL != 1) begin : g_bad_pol
    $error("vga_axis_counter: POL must be 0 or 1");
  end

  assign wrap      = (count == LAST);
  assign in_active = (count <= ACT_LAST);
  assign in_sync   = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with pixel-rate enable. Ports: clkin/reset,
// pix_en; VGA_HS/VGA_VS (polarity per H_POL/V_POL), activeVideo, vblank,
// line_start, frame_start, pix_x/pix_y -- all registered, one enabled cycle late.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int H_POL    = VGA640_H_POL,
  parameter int V_POL    = VGA640_V_POL,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pix_en,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             activeVideo,
  output logic             vblank,
  output logic             line_start,
  output logic             frame_start,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y
);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, h_active, h_sync;
  logic             v_wrap_unused, v_active, v_sync;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
  ) u_h (
    .clkin    (clkin),
    .reset    (reset),
    .step     (pix_en),
    .count    (h_count),
    .wrap     (h_wrap),
    .in_active(h_active),
    .in_sync  (h_sync)
  );

  // The vertical axis moves on the same enabled edge that takes h back to 0.
  // Its own wrap is implicit in the counter; nothing downstream needs it.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
  ) u_v (
    .clkin    (clkin),
    .reset    (reset),
    .step     (pix_en & h_wrap),
    .count    (v_count),
    .wrap     (v_wrap_unused),
    .in_active(v_active),
    .in_sync  (v_sync)
  );

  // Every output is decoded from the pre-increment counts on the same enabled
  // edge, so all of them describe one (h,v) position and stay mutually aligned.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pix_x       <= '0;
      pix_y       <= '0;
      activeVideo <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      VGA_HS      <= ~HS_ON;
      VGA_VS      <= ~VS_ON;
    end else if (pix_en) begin
      pix_x       <= h_count;
      pix_y       <= v_count;
      activeVideo <= h_active & v_active;
      vblank      <= ~v_active;
      line_start  <= (h_count == '0);
      frame_start <= (h_count == '0) && (v_count == '0);
      VGA_HS      <= h_sync ? HS_ON : ~HS_ON;
      VGA_VS      <= v_sync ? VS_ON : ~VS_ON;
    end
  end

endmodule
